// File: rtl/uart_dv_pkg.sv
// Shared types and helpers for the DV-side UART receive sink.
package uart_dv_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  function automatic int unsigned cycles_per_symbol(input int unsigned freq,
                                                    input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uartdpi_rx_fifo.sv
// First-word-fall-through sync FIFO; the head byte is held in a register so it
// keeps its last value once the FIFO drains.
module uartdpi_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_fatal
    $fatal(1, "uartdpi_rx_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q, rptr_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_d;
  logic             pop_acc, push_acc;

  // Pop needs data present; a push into a full FIFO only lands if a pop frees a slot.
  always_comb begin
    pop_acc  = pop_i && valid_o;
    push_acc = push_i && (!full_o || pop_acc);
    rptr_nxt = rptr_q + PTR_W'(1);
    cnt_d    = cnt_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
    rdata_d  = rdata_o;
    if (pop_acc && cnt_q > CNT_W'(1)) begin
      rdata_d = mem[rptr_nxt];
    end else if (push_acc && (cnt_q == '0 || (pop_acc && cnt_q == CNT_W'(1)))) begin
      rdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      mem[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      valid_o <= 1'b0;
      full_o  <= 1'b0;
      rdata_o <= '0;
    end else begin
      if (push_acc) wptr_q <= wptr_q + PTR_W'(1);
      if (pop_acc)  rptr_q <= rptr_nxt;
      cnt_q   <= cnt_d;
      valid_o <= (cnt_d != '0);
      full_o  <= (cnt_d == CNT_W'(DEPTH));
      rdata_o <= rdata_d;
    end
  end

endmodule

// File: rtl/uartdpi_rx_sink.sv
// UART 8N1 receiver for DV harnesses: synchronises rx_i, deserialises bytes
// into a FWFT FIFO and pulses on framing errors and dropped bytes.
module uartdpi_rx_sink
  import uart_dv_pkg::*;
#(
  parameter int unsigned BAUD  = 115200,
  parameter int unsigned FREQ  = 50_000_000,
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_i,
  output logic [BYTE_W-1:0] rdata_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic              overflow_o
);

  localparam int unsigned CPS   = cycles_per_symbol(FREQ, BAUD);
  localparam int unsigned CYC_W = $clog2(CPS);
  localparam logic [CYC_W-1:0] HALF_LAST = CYC_W'(CPS / 2 - 1);
  localparam logic [CYC_W-1:0] BIT_LAST  = CYC_W'(CPS - 1);

  if (CPS < 4) begin : g_cps_fatal
    $fatal(1, "uartdpi_rx_sink: FREQ/BAUD must be >= 4");
  end

  logic [1:0]        sync_q;
  logic              rx_s;
  rx_state_e         state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              push_c, frame_err_d, overflow_d;
  logic              fifo_full;

  assign rx_s = sync_q[1];

  // Next-state: every decision is taken on the synchronised line.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q + CYC_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_c      = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        bit_idx_d = '0;
        if (cyc_q == HALF_LAST) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cyc_q == BIT_LAST) begin
          if (rx_s) begin
            push_c  = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cyc_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cyc_d = '0;
    overflow_d = push_c && fifo_full && !(ready_i && valid_o);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      cyc_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      busy_o      <= 1'b0;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx_i};
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      busy_o      <= (state_d != IDLE);
      frame_err_o <= frame_err_d;
      overflow_o  <= overflow_d;
    end
  end

  uartdpi_rx_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_c),
    .wdata_i (shift_d),
    .pop_i   (ready_i),
    .full_o  (fifo_full),
    .valid_o (valid_o),
    .rdata_o (rdata_o)
  );

endmodule

// File: tb/tb_uartdpi_rx_sink.sv
// Scoreboard bench for uartdpi_rx_sink at CPS=8: good bytes are queued when
// sent and compared as the consumer pops them.
module tb_uartdpi_rx_sink;

  localparam int unsigned FREQ  = 800;
  localparam int unsigned BAUD  = 100;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CPS   = 8;

  logic       clk_i   = 1'b0;
  logic       rst_ni  = 1'b0;
  logic       rx_i    = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] rdata_o;
  logic       valid_o, busy_o, frame_err_o, overflow_o;

  int unsigned n_cmp = 0, n_err = 0;
  int unsigned valid_cnt = 0, ferr_cnt = 0, ovf_cnt = 0;
  int unsigned v0, f0, o0;
  logic [7:0]  sb [$];

  always #5 clk_i = ~clk_i;

  uartdpi_rx_sink #(
    .BAUD  (BAUD),
    .FREQ  (FREQ),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .rdata_o     (rdata_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
    .overflow_o  (overflow_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Consumer-side monitor: handshakes seen here complete on the next posedge.
  always @(negedge clk_i) begin : mon
    logic [7:0] exp_b;
    if (rst_ni) begin
      if (valid_o)     valid_cnt++;
      if (frame_err_o) ferr_cnt++;
      if (overflow_o)  ovf_cnt++;
      if (valid_o && ready_i) begin
        check_eq("pop_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_b = sb.pop_front();
          check_eq("rx_byte", 32'(rdata_o), 32'(exp_b));
        end
      end
    end
  end

  task automatic idle(input int unsigned n);
    rx_i = 1'b1;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (CPS) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic expect_rx);
    if (expect_rx) sb.push_back(b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic snap();
    v0 = valid_cnt;
    f0 = ferr_cnt;
    o0 = ovf_cnt;
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_rdata", 32'(rdata_o), 32'h0);
    check_eq("rst_valid", 32'(valid_o), 32'h0);
    check_eq("rst_busy", 32'(busy_o), 32'h0);
    check_eq("rst_ferr", 32'(frame_err_o), 32'h0);
    check_eq("rst_ovf", 32'(overflow_o), 32'h0);
    rst_ni = 1'b1;
    idle(4);

    // Plain byte with an always-ready consumer
    ready_i = 1'b1;
    snap();
    send_frame(8'h55, 1'b1, 1'b1);
    idle(20);
    check_eq("t1_valid_cycles", valid_cnt - v0, 32'd1);
    check_eq("t1_ferr", ferr_cnt - f0, 32'd0);
    check_eq("t1_ovf", ovf_cnt - o0, 32'd0);
    check_eq("t1_drained", 32'(sb.size()), 32'd0);

    // Short low glitch must be rejected at the start-bit midpoint
    snap();
    rx_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rx_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("t2_busy_in_glitch", 32'(busy_o), 32'd1);
    idle(20);
    check_eq("t2_busy_after", 32'(busy_o), 32'd0);
    check_eq("t2_valid_cycles", valid_cnt - v0, 32'd0);
    check_eq("t2_ferr", ferr_cnt - f0, 32'd0);

    // Framing error followed by a held-low line, then a good byte
    snap();
    send_frame(8'hA3, 1'b0, 1'b0);
    rx_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;
    check_eq("t3_busy_wait_idle", 32'(busy_o), 32'd1);
    repeat (20) @(posedge clk_i);
    #1;
    idle(16);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(20);
    check_eq("t3_ferr", ferr_cnt - f0, 32'd1);
    check_eq("t3_ovf", ovf_cnt - o0, 32'd0);
    check_eq("t3_valid_cycles", valid_cnt - v0, 32'd1);
    check_eq("t3_drained", 32'(sb.size()), 32'd0);

    // Overflow: DEPTH+1 bytes into a stalled FIFO
    ready_i = 1'b0;
    snap();
    for (int i = 0; i <= int'(DEPTH); i++) send_frame(8'(i), 1'b1, i < int'(DEPTH));
    idle(10);
    check_eq("t4_ovf", ovf_cnt - o0, 32'd1);
    check_eq("t4_ferr", ferr_cnt - f0, 32'd0);
    check_eq("t4_valid", 32'(valid_o), 32'd1);
    check_eq("t4_head", 32'(rdata_o), 32'h00);
    ready_i = 1'b1;
    idle(20);
    check_eq("t4_drained", 32'(sb.size()), 32'd0);
    check_eq("t4_empty", 32'(valid_o), 32'd0);
    check_eq("t4_rdata_hold", 32'(rdata_o), 32'h07);
    ready_i = 1'b0;

    // Full FIFO: pop coincides with the push of the next byte
    for (int i = 0; i < int'(DEPTH); i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b1);
    idle(4);
    snap();
    sb.push_back(8'h7E);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(((8'h7E >> i) & 8'h01) != 8'h00);
    rx_i = 1'b1;
    repeat (CPS - 2) @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    check_eq("t5_ovf_pulse", 32'(overflow_o), 32'd0);
    check_eq("t5_still_valid", 32'(valid_o), 32'd1);
    idle(10);
    check_eq("t5_ovf", ovf_cnt - o0, 32'd0);
    check_eq("t5_pending", 32'(sb.size()), 32'(DEPTH));
    ready_i = 1'b1;
    idle(20);
    check_eq("t5_drained", 32'(sb.size()), 32'd0);
    check_eq("t5_last", 32'(rdata_o), 32'h7E);

    // Reset in the middle of a frame discards the partial byte
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("t6_rst_rdata", 32'(rdata_o), 32'h0);
    check_eq("t6_rst_valid", 32'(valid_o), 32'h0);
    check_eq("t6_rst_busy", 32'(busy_o), 32'h0);
    check_eq("t6_rst_ferr", 32'(frame_err_o), 32'h0);
    check_eq("t6_rst_ovf", 32'(overflow_o), 32'h0);
    rst_ni = 1'b1;
    snap();
    idle(16);
    send_frame(8'h12, 1'b1, 1'b1);
    idle(20);
    check_eq("t6_valid_cycles", valid_cnt - v0, 32'd1);
    check_eq("t6_drained", 32'(sb.size()), 32'd0);
    check_eq("t6_busy", 32'(busy_o), 32'd0);
    check_eq("t6_ferr", ferr_cnt - f0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
